// File: rtl/gate_operand_gen.sv
// gate_operand_gen: operand-pair stimulus source for two-operand gate blocks.
// Emits a programmable number of (a, b) pairs on a valid/ready handshake,
// either counting exhaustively through all 2^(2*WIDTH) combinations or
// stepping a 16-bit Fibonacci LFSR (taps 16,14,13,11).
module gate_operand_gen #(
    parameter int          WIDTH = 5,
    parameter logic [15:0] SEED  = 16'hACE1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             mode,
    input  logic [15:0]      num_vec,
    input  logic             out_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] a,
    output logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [15:0]      vec_cnt
);

    localparam int W2 = 2 * WIDTH;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIN  = 2'd2
    } state_t;

    // One LFSR step: feedback from bits 15,13,12,10 shifted in at bit 0.
    function automatic logic [15:0] lfsr_step(input logic [15:0] s);
        lfsr_step = {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
    endfunction

    state_t             state_r, state_s;
    logic               mode_r, mode_s;
    logic [15:0]        num_r, num_s;
    logic [W2-1:0]      cnt_r, cnt_s;
    logic [15:0]        lfsr_r, lfsr_s;
    logic [WIDTH-1:0]   a_s, b_s;
    logic               valid_s, busy_s, done_s;
    logic [15:0]        vec_s;
    logic               xfer_s;

    assign xfer_s = out_valid & out_ready;

    // Next-state and next-output computation for the IDLE/RUN/FIN controller.
    always_comb begin
        state_s = state_r;
        mode_s  = mode_r;
        num_s   = num_r;
        cnt_s   = cnt_r;
        lfsr_s  = lfsr_r;
        a_s     = a;
        b_s     = b;
        valid_s = out_valid;
        busy_s  = busy;
        done_s  = 1'b0;
        vec_s   = vec_cnt;
        case (state_r)
            IDLE: begin
                if (start) begin
                    vec_s = 16'd0;
                    if (num_vec != 16'd0) begin
                        // Restart both generators so every run begins at vector 0.
                        state_s = RUN;
                        mode_s  = mode;
                        num_s   = num_vec;
                        cnt_s   = {W2{1'b0}};
                        lfsr_s  = SEED;
                        valid_s = 1'b1;
                        busy_s  = 1'b1;
                        if (mode) begin
                            a_s = SEED[W2-1:WIDTH];
                            b_s = SEED[WIDTH-1:0];
                        end else begin
                            a_s = {WIDTH{1'b0}};
                            b_s = {WIDTH{1'b0}};
                        end
                    end else begin
                        state_s = FIN;
                        done_s  = 1'b1;
                    end
                end else begin
                    state_s = IDLE;
                end
            end
            RUN: begin
                if (xfer_s) begin
                    // Advance and present the next vector immediately (no bubble).
                    vec_s  = vec_cnt + 16'd1;
                    cnt_s  = cnt_r + W2'(1);
                    lfsr_s = lfsr_step(lfsr_r);
                    if (mode_r) begin
                        a_s = lfsr_s[W2-1:WIDTH];
                        b_s = lfsr_s[WIDTH-1:0];
                    end else begin
                        a_s = cnt_s[W2-1:WIDTH];
                        b_s = cnt_s[WIDTH-1:0];
                    end
                    if (vec_s == num_r) begin
                        state_s = FIN;
                        valid_s = 1'b0;
                        busy_s  = 1'b0;
                        done_s  = 1'b1;
                    end else begin
                        state_s = RUN;
                    end
                end else begin
                    state_s = RUN;
                end
            end
            FIN: begin
                state_s = IDLE;
            end
            default: begin
                state_s = IDLE;
                valid_s = 1'b0;
                busy_s  = 1'b0;
            end
        endcase
    end

    // State and registered outputs; asynchronous reset returns everything to idle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= IDLE;
            mode_r    <= 1'b0;
            num_r     <= 16'd0;
            cnt_r     <= {W2{1'b0}};
            lfsr_r    <= SEED;
            a         <= {WIDTH{1'b0}};
            b         <= {WIDTH{1'b0}};
            out_valid <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            vec_cnt   <= 16'd0;
        end else begin
            state_r   <= state_s;
            mode_r    <= mode_s;
            num_r     <= num_s;
            cnt_r     <= cnt_s;
            lfsr_r    <= lfsr_s;
            a         <= a_s;
            b         <= b_s;
            out_valid <= valid_s;
            busy      <= busy_s;
            done      <= done_s;
            vec_cnt   <= vec_s;
        end
    end

endmodule

// File: tb/tb_gate_operand_gen.sv
// Testbench for gate_operand_gen: directed and randomized runs checked against
// a vector-index based reference model (exhaustive) and an arithmetic LFSR.
module tb_gate_operand_gen;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        start, mode, out_ready;
    logic [15:0] num_vec;
    logic        out_valid, busy, done;
    logic [4:0]  a, b;
    logic [15:0] vec_cnt;

    logic        st2, md2, rdy2;
    logic [15:0] nv2;
    logic        valid2, busy2, done2;
    logic [1:0]  a2, b2;
    logic [15:0] vec_cnt2;

    int checks   = 0;
    int failures = 0;

    gate_operand_gen #(.WIDTH(5), .SEED(16'hACE1)) u_dut5 (
        .clk(clk), .rst_n(rst_n), .start(start), .mode(mode), .num_vec(num_vec),
        .out_ready(out_ready), .out_valid(out_valid), .a(a), .b(b),
        .busy(busy), .done(done), .vec_cnt(vec_cnt)
    );

    gate_operand_gen #(.WIDTH(2), .SEED(16'hACE1)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .start(st2), .mode(md2), .num_vec(nv2),
        .out_ready(rdy2), .out_valid(valid2), .a(a2), .b(b2),
        .busy(busy2), .done(done2), .vec_cnt(vec_cnt2)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference LFSR step written as plain integer arithmetic.
    function automatic int lfsr_next(input int s);
        int fb;
        fb = ((s >> 15) ^ (s >> 13) ^ (s >> 12) ^ (s >> 10)) & 1;
        return ((s << 1) | fb) & 32'hFFFF;
    endfunction

    // One run on the WIDTH=5 instance. rmode: 0 ready always, 1 fixed pattern,
    // 2 random ready. hold_start keeps start high through the run.
    task automatic run5(input bit m, input int n, input int rmode, input bit hold_start);
        int k = 0;
        int cyc = 0;
        int idx = 0;
        int s = 32'hACE1;
        int ea, eb;
        bit r;
        bit held = 1'b0;
        logic [4:0] ha, hb;
        int pat[7] = '{1, 0, 0, 1, 1, 0, 1};
        @(negedge clk);
        start = 1'b1; mode = m; num_vec = 16'(n); out_ready = 1'b0;
        @(negedge clk);
        start = hold_start; mode = ~m; num_vec = 16'($urandom);
        while (k < n && cyc < n * 20 + 50) begin
            check("valid", {31'd0, out_valid}, 32'd1);
            check("busy", {31'd0, busy}, 32'd1);
            check("done_run", {31'd0, done}, 32'd0);
            check("vec_cnt", {16'd0, vec_cnt}, k);
            if (held) begin
                check("hold_a", {27'd0, a}, {27'd0, ha});
                check("hold_b", {27'd0, b}, {27'd0, hb});
            end
            if (rmode == 0) r = 1'b1;
            else if (rmode == 1) r = (idx < 7) ? (pat[idx] != 0) : 1'b1;
            else r = ($urandom_range(0, 1) != 0);
            idx++;
            if (r) begin
                if (m) begin
                    ea = (s >> 5) & 31;
                    eb = s & 31;
                end else begin
                    ea = (k % 1024) / 32;
                    eb = k % 32;
                end
                check("a", {27'd0, a}, ea);
                check("b", {27'd0, b}, eb);
                k++;
                s = lfsr_next(s);
                held = 1'b0;
            end else begin
                held = 1'b1;
                ha = a;
                hb = b;
            end
            out_ready = r;
            @(negedge clk);
            cyc++;
        end
        start = 1'b0;
        out_ready = 1'b0;
        check("timeout", k, n);
        check("valid_fin", {31'd0, out_valid}, 32'd0);
        check("busy_fin", {31'd0, busy}, 32'd0);
        check("done_fin", {31'd0, done}, 32'd1);
        check("vec_cnt_fin", {16'd0, vec_cnt}, n);
        @(negedge clk);
        check("done_pulse", {31'd0, done}, 32'd0);
        check("valid_idle", {31'd0, out_valid}, 32'd0);
        check("vec_cnt_hold", {16'd0, vec_cnt}, n);
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b0; mode = 1'b0; num_vec = 16'd0; out_ready = 1'b0;
        st2 = 1'b0; md2 = 1'b0; nv2 = 16'd0; rdy2 = 1'b1;
        #12;
        check("rst_valid", {31'd0, out_valid}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_a", {27'd0, a}, 32'd0);
        check("rst_b", {27'd0, b}, 32'd0);
        check("rst_vec_cnt", {16'd0, vec_cnt}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Directed runs from the test plan.
        run5(1'b0, 3, 0, 1'b0);
        run5(1'b1, 2, 0, 1'b0);
        run5(1'b0, 4, 1, 1'b0);
        run5(1'b0, 0, 0, 1'b0);
        run5(1'b0, 6, 0, 1'b1);

        // Wrap on the WIDTH=2 instance: 17 vectors through a 16-entry space.
        @(negedge clk);
        st2 = 1'b1; md2 = 1'b0; nv2 = 16'd17;
        @(negedge clk);
        st2 = 1'b0;
        for (int k = 0; k < 17; k++) begin
            check("w2_valid", {31'd0, valid2}, 32'd1);
            check("w2_a", {30'd0, a2}, (k % 16) / 4);
            check("w2_b", {30'd0, b2}, k % 4);
            check("w2_vec_cnt", {16'd0, vec_cnt2}, k);
            @(negedge clk);
        end
        check("w2_valid_fin", {31'd0, valid2}, 32'd0);
        check("w2_done", {31'd0, done2}, 32'd1);
        check("w2_vec_cnt_fin", {16'd0, vec_cnt2}, 32'd17);

        // Asynchronous reset in the middle of a run.
        @(negedge clk);
        start = 1'b1; mode = 1'b0; num_vec = 16'd10; out_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        check("mid_vec_cnt", {16'd0, vec_cnt}, 32'd3);
        #2 rst_n = 1'b0;
        #1;
        check("ar_valid", {31'd0, out_valid}, 32'd0);
        check("ar_busy", {31'd0, busy}, 32'd0);
        check("ar_a", {27'd0, a}, 32'd0);
        check("ar_b", {27'd0, b}, 32'd0);
        check("ar_vec_cnt", {16'd0, vec_cnt}, 32'd0);
        check("ar_done", {31'd0, done}, 32'd0);
        @(negedge clk);
        check("ar_no_done", {31'd0, done}, 32'd0);
        rst_n = 1'b1;
        out_ready = 1'b0;
        @(negedge clk);
        start = 1'b1; mode = 1'b1; num_vec = 16'd5;
        @(negedge clk);
        start = 1'b0;
        check("ar_rnd_valid", {31'd0, out_valid}, 32'd1);
        check("ar_rnd_a", {27'd0, a}, 32'd7);
        check("ar_rnd_b", {27'd0, b}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("ar2_valid", {31'd0, out_valid}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        run5(1'b0, 2, 0, 1'b0);

        // Randomized runs with random backpressure.
        for (int i = 0; i < 6; i++) begin
            run5(($urandom_range(0, 1) != 0), $urandom_range(1, 40), 2, 1'b0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/gate_operand_gen.md
Name: gate_operand_gen

Overview:
Upstream stimulus stage for the parameterised two-operand gate blocks (AND and its siblings). It produces a programmable number of operand pairs (a, b) on a valid/ready handshake, either exhaustively or pseudo-randomly from an LFSR. Its a/b outputs drive the gate's a/b inputs directly; the consumer or result checker supplies out_ready.

Parameters:
WIDTH, 5, operand width of a and b; legal range 1..8, so 2*WIDTH <= 16.
SEED, 16'hACE1, LFSR reload value; must be nonzero.

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  begin a run; sampled only in IDLE
mode  input  1  0 = exhaustive, 1 = LFSR random; latched on start
num_vec  input  16  number of vectors in the run; latched on start
out_ready  input  1  consumer accepts the current vector
out_valid  output  1  a/b hold a valid vector
a  output  WIDTH  operand A
b  output  WIDTH  operand B
busy  output  1  run in progress
done  output  1  one-cycle pulse at the end of a run
vec_cnt  output  16  vectors accepted in the current or last run

Behaviour:
- One clock domain, clk. Reset is asynchronous and active-low (rst_n).
- Reset values: state IDLE; out_valid, busy, done = 0; a, b, vec_cnt = 0; LFSR = SEED; exhaustive counter = 0.
- All outputs are registered.
- FSM states: IDLE, RUN, FIN.
- IDLE -> RUN when start = 1 and num_vec != 0.
  - On that edge: latch mode and num_vec, clear vec_cnt, reload LFSR = SEED, clear counter.
  - out_valid and busy rise the next cycle and present vector 0.
- IDLE -> FIN when start = 1 and num_vec = 0. No vector is emitted; vec_cnt is cleared.
- start is ignored outside IDLE. mode and num_vec changes during a run are ignored.
- Handshake in RUN:
  - A transfer occurs on an edge where out_valid = 1 and out_ready = 1.
  - On a transfer: vec_cnt += 1 and the generator advances one step.
  - While out_valid = 1 and out_ready = 0, a and b hold stable.
  - out_valid never drops until the last transfer.
- The transfer that makes vec_cnt = latched num_vec moves the FSM to RUN -> FIN. out_valid and busy drop on the same edge.
- FIN: done = 1 for exactly one cycle, then IDLE. vec_cnt holds its value until the next start.
- Exhaustive mode:
  - Counter C is 2*WIDTH bits, starts at 0, and increments per transfer.
  - a = C[2W-1:W], b = C[W-1:0].
  - C wraps modulo 2^(2W) and continues counting.
- Random mode:
  - 16-bit Fibonacci LFSR s, taps 16,14,13,11.
  - fb = s[15]^s[13]^s[12]^s[10]; next s = {s[14:0], fb}.
  - a = s[2W-1:W], b = s[W-1:0]. s steps once per transfer.
- Output update: a and b show the current generator state combined into registered outputs. The next vector appears the cycle after a transfer, with no bubble; out_valid stays 1 when out_ready is held high.
- Reset mid-run: immediate return to reset values. No done pulse.
- num_vec = 65535 is legal. The 16-bit vec_cnt never overflows within a run.

Test Plan:
- WIDTH=5, mode=0, num_vec=3, out_ready=1: (a,b) = (0,0),(0,1),(0,2) on 3 consecutive cycles. done pulses 1 cycle later. vec_cnt = 3; busy = 0 afterwards.
- WIDTH=5, mode=1, num_vec=2, out_ready=1: first vector a=7, b=1 (s=0xACE1); second a=14, b=3 (s=0x59C3). Then done.
- Backpressure: mode=0, num_vec=4, out_ready toggling 1,0,0,1,1,0,1. a/b stay stable during the 0 cycles. Exactly 4 transfers with b = 0,1,2,3; vec_cnt increments only on transfers.
- num_vec=0 with start: out_valid is never asserted, done pulses once, vec_cnt = 0. A start pulse held during RUN is ignored and causes no restart.
- Wrap: WIDTH=2, mode=0, num_vec=17: vector 16 is (3,3) and vector 17 is (0,0). vec_cnt = 17.
- Async reset: assert rst_n=0 mid-run, between clock edges. out_valid, busy, a, b and vec_cnt go to 0 immediately with no done pulse. A new start then yields the first vector again, (0,0), or a=7, b=1 in random mode.
